// File: rtl/op_imm_sequencer.sv
// op_imm_sequencer
//
// Issue and writeback sequencer for RV32I OP-IMM instructions. It owns a
// 32x32 register file and sits on both ends of the register-immediate ALU.
// An instruction is accepted in IDLE and its fields are decoded. The ALU
// operands are registered in READ, and the ALU is enabled for the single
// EXEC cycle. The ALU result is written back to rd at the edge that ends WB.
//
// Ports:
//   clock                  core clock, rising edge
//   reset_n                asynchronous active-low reset
//   instr_valid / instr    instruction word and its valid flag
//   instr_ready            high only in IDLE
//   alu_enable             one-cycle ALU enable (EXEC)
//   alu_funct3             funct3 of the instruction in flight
//   alu_rs1_value          register file value of rs1 (x0 reads 0)
//   alu_immediate12_itype  sign-extended I-type immediate
//   alu_rd_value           ALU result, sampled only in WB
//   done                   high during WB
//   illegal_instr          one-cycle pulse after a rejected handshake
//   dbg_addr / dbg_data    combinational debug read port (x0 reads 0)

module op_imm_sequencer #(
    parameter int          XLEN          = 32,
    parameter logic [6:0]  OPCODE_OP_IMM = 7'b0010011
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            alu_enable,
    output logic [2:0]      alu_funct3,
    output logic [XLEN-1:0] alu_rs1_value,
    output logic [XLEN-1:0] alu_immediate12_itype,
    input  logic [XLEN-1:0] alu_rd_value,
    output logic            done,
    output logic            illegal_instr,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Fields of the accepted instruction, held until writeback
    logic [2:0]  funct3_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rd_q;
    logic [11:0] imm_q;

    logic [XLEN-1:0] regs [32];

    logic handshake;
    logic legal;
    logic [XLEN-1:0] rs1_read;

    assign handshake = instr_valid && instr_ready;

    // Shifts (funct3 1 and 5) belong to a different unit and are rejected here
    assign legal = (instr[6:0] == OPCODE_OP_IMM) &&
                   (instr[14:12] != 3'd1) && (instr[14:12] != 3'd5);

    assign rs1_read = (rs1_q == 5'd0) ? '0 : regs[rs1_q];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and the control strobes. alu_enable and done are decoded
    // straight from the state, so they drop asynchronously with reset.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        alu_enable  = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (handshake && legal) begin
                    next_state = READ;
                end
            end
            READ: begin
                next_state = EXEC;
            end
            EXEC: begin
                alu_enable = 1'b1;
                next_state = WB;
            end
            WB: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the decoded fields on a handshake. A rejected instruction
    // only produces the illegal pulse in the following cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            funct3_q      <= '0;
            rs1_q         <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            illegal_instr <= 1'b0;
        end else begin
            illegal_instr <= handshake && !legal;
            if (handshake && legal) begin
                funct3_q <= instr[14:12];
                rs1_q    <= instr[19:15];
                rd_q     <= instr[11:7];
                imm_q    <= instr[31:20];
            end
        end
    end

    // ALU operands are loaded at the edge ending READ and held otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_funct3            <= '0;
            alu_rs1_value         <= '0;
            alu_immediate12_itype <= '0;
        end else if (state == READ) begin
            alu_funct3            <= funct3_q;
            alu_rs1_value         <= rs1_read;
            alu_immediate12_itype <= {{(XLEN-12){imm_q[11]}}, imm_q};
        end
    end

    // Register file. x0 is never written, so it stays at its reset value
    // of zero; a reset during WB wins over the pending write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if ((state == WB) && (rd_q != 5'd0)) begin
            regs[rd_q] <= alu_rd_value;
        end
    end

endmodule
